// File: rtl/inst_rom_loader_if.sv
// Loader byte stream, CPU fetch port and status bundle for inst_rom_loader.
// The ROM is the slave side of this bundle. The loader, the CPU and the bench are the master side.
interface inst_rom_loader_if #(
    parameter int DEPTH_LOG2 = 8
);
    logic                  load_start;
    logic                  load_valid;
    logic [7:0]            load_byte;
    logic                  load_last;
    logic                  load_ready;
    logic [31:0]           next_inst_addr;
    logic                  read_enable_cpu;
    logic [31:0]           inst;
    logic                  go;
    logic [DEPTH_LOG2:0]   words_loaded;
    logic                  overflow;
    logic [31:0]           checksum;

    modport master (
        output load_start, load_valid, load_byte, load_last,
        output next_inst_addr, read_enable_cpu,
        input  load_ready, inst, go, words_loaded, overflow, checksum
    );

    modport slave (
        input  load_start, load_valid, load_byte, load_last,
        input  next_inst_addr, read_enable_cpu,
        output load_ready, inst, go, words_loaded, overflow, checksum
    );
endinterface

// File: rtl/inst_rom_loader.sv
// Instruction ROM filled from a little-endian byte stream and read by the CPU fetch port.
// Optional macro ROM_CHECKSUM_EN enables a running 32-bit sum of every word written.
module inst_rom_loader #(
    parameter int          DEPTH_LOG2 = 8,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 reset,
    inst_rom_loader_if.slave     bus
);

    localparam int                  DEPTH    = 1 << DEPTH_LOG2;
    localparam int                  WL_W     = DEPTH_LOG2 + 1;
    localparam logic [WL_W-1:0]     FULL_CNT = WL_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WL_W-1:0]     words_q, words_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [31:0]         asm_q, asm_d;
    logic                overflow_q, overflow_d;

    logic                we;
    logic [DEPTH_LOG2-1:0] waddr;
    logic [31:0]         wdata;
    logic [31:0]         merged;
    logic                rom_full;

    logic [31:0]         mem [DEPTH];

    // Bytes above the current position are still zero in asm_q, so a final
    // partial word comes out zero-padded without extra masking.
    assign merged   = asm_q | ({24'h0, bus.load_byte} << {byte_cnt_q, 3'b000});
    assign rom_full = (words_q == FULL_CNT);

    always_comb begin
        state_d    = state_q;
        words_d    = words_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        overflow_d = overflow_q;
        we         = 1'b0;
        waddr      = words_q[DEPTH_LOG2-1:0];
        wdata      = merged;

        if (bus.load_start) begin
            state_d    = S_LOAD;
            words_d    = '0;
            byte_cnt_d = '0;
            asm_d      = '0;
            overflow_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: ;
                S_LOAD: begin
                    if (bus.load_valid) begin
                        if (rom_full) begin
                            overflow_d = 1'b1;
                        end else if (byte_cnt_q == 2'd3 || bus.load_last) begin
                            we         = 1'b1;
                            words_d    = words_q + 1'b1;
                            byte_cnt_d = '0;
                            asm_d      = '0;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 1'b1;
                            asm_d      = merged;
                        end
                        if (bus.load_last) begin
                            state_d = S_RUN;
                        end
                    end
                end
                S_RUN: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            words_q    <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            words_q    <= words_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately left out of reset; stale words sit above words_loaded.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

`ifdef ROM_CHECKSUM_EN
    logic [31:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (bus.load_start) begin
            checksum_d = '0;
        end else if (we) begin
            checksum_d = checksum_q + wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign bus.checksum = checksum_q;
`else
    assign bus.checksum = 32'h0;
`endif

    logic [DEPTH_LOG2-1:0] rd_idx;
    logic                  addr_in_range;
    logic                  fetch_hit;
    logic                  unused_addr_lsbs;

    // Fetch is purely combinational. Addresses beyond the ROM or beyond the loaded image read as NOP.
    assign rd_idx           = bus.next_inst_addr[DEPTH_LOG2+1:2];
    assign addr_in_range    = (bus.next_inst_addr[31:DEPTH_LOG2+2] == '0);
    assign fetch_hit        = (state_q == S_RUN) && bus.read_enable_cpu && addr_in_range &&
                              ({1'b0, rd_idx} < words_q);
    assign bus.inst         = fetch_hit ? mem[rd_idx] : NOP_WORD;
    assign unused_addr_lsbs = ^bus.next_inst_addr[1:0];

    assign bus.go           = (state_q == S_RUN);
    assign bus.load_ready   = (state_q == S_LOAD);
    assign bus.words_loaded = words_q;
    assign bus.overflow     = overflow_q;

endmodule
